// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter mode constants, MAX helper and modulus legality check
package counter_pkg;

  localparam logic CNT_MODE_WRAP     = 1'b0;
  localparam logic CNT_MODE_SATURATE = 1'b1;

  function automatic longint cnt_max(input longint modulus);
    return modulus - 64'sd1;
  endfunction

  // Width is capped so the 2**WIDTH bound stays representable in a longint.
  function automatic bit cnt_modulus_legal(input int width, input longint modulus);
    return (width >= 1) && (width <= 62) &&
           (modulus >= 64'sd2) && (modulus <= (64'sd1 <<< width));
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - control and status bundle of the up/down modulus counter
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             upordown;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en, upordown, load, load_value,
    input  count, tc, wrap
  );

  modport slave (
    input  en, upordown, load, load_value,
    output count, tc, wrap
  );

endinterface

// File: rtl/updown_mod_counter_step.sv
// rtl/updown_mod_counter_step.sv - combinational next-count and wrap decode for one enabled step
module updown_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             upordown,
  input  logic [WIDTH-1:0] max_value,
  input  logic             mode,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);

  always_comb begin
    next_count = count;
    wrap       = 1'b0;
    if (upordown) begin
      if (count < max_value) begin
        next_count = count + WIDTH'(1);
      end else if (mode == CNT_MODE_WRAP) begin
        next_count = '0;
        wrap       = 1'b1;
      end
    end else begin
      if (count != '0) begin
        next_count = count - WIDTH'(1);
      end else if (mode == CNT_MODE_WRAP) begin
        next_count = max_value;
        wrap       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down counter with programmable modulus, load clamp, tc and wrap pulse
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input logic                clk,
  input logic                reset,
  updown_mod_counter_if.slave bus
);

  if (!cnt_modulus_legal(WIDTH, longint'(MODULUS))) begin : g_illegal_modulus
    $error("updown_mod_counter: MODULUS must lie in 2 .. 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(cnt_max(longint'(MODULUS)));
  localparam logic             MODE = (SATURATE != 0) ? CNT_MODE_SATURATE : CNT_MODE_WRAP;

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] step_count;
  logic             step_wrap;
  logic [WIDTH-1:0] load_clamped;

  updown_step #(.WIDTH(WIDTH)) u_step (
    .count      (count_q),
    .upordown   (bus.upordown),
    .max_value  (MAX),
    .mode       (MODE),
    .next_count (step_count),
    .wrap       (step_wrap)
  );

  assign load_clamped = (bus.load_value > MAX) ? MAX : bus.load_value;

  // Priority reset > load > en; wrap is a single-cycle pulse cleared on every other path.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      wrap_q  <= 1'b0;
    end else if (bus.en) begin
      count_q <= step_count;
      wrap_q  <= step_wrap;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = bus.upordown ? (count_q == MAX) : (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - scoreboard bench for wrap and saturate counter instances
module tb_updown_mod_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(4)) if_w ();
  updown_mod_counter_if #(.WIDTH(4)) if_s ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (if_w)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (if_s)
  );

  typedef struct {
    int         sel;
    logic [3:0] c;
    logic       w;
    logic       t;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Inputs change on the falling edge; outputs are checked just after the rising edge that used them.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t       e;
      logic [3:0] ac;
      logic       aw;
      logic       at;
      e  = sb.pop_front();
      ac = (e.sel == 0) ? if_w.count : if_s.count;
      aw = (e.sel == 0) ? if_w.wrap  : if_s.wrap;
      at = (e.sel == 0) ? if_w.tc    : if_s.tc;
      tests++;
      if (ac !== e.c || aw !== e.w || at !== e.t) begin
        fails++;
        $display("FAIL %s: got count=%0d wrap=%b tc=%b, want count=%0d wrap=%b tc=%b",
                 e.name, ac, aw, at, e.c, e.w, e.t);
      end
    end
  end

  task automatic apply(input int sel, input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv,
                       input logic [3:0] ec, input logic ew, input logic et,
                       input string nm);
    exp_t x;
    @(negedge clk);
    reset           = r;
    if_w.en         = e;
    if_w.upordown   = u;
    if_w.load       = l;
    if_w.load_value = lv;
    if_s.en         = e;
    if_s.upordown   = u;
    if_s.load       = l;
    if_s.load_value = lv;
    x.sel  = sel;
    x.c    = ec;
    x.w    = ew;
    x.t    = et;
    x.name = nm;
    sb.push_back(x);
  endtask

  logic [3:0] up_wrap_c [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic [3:0] up_sat_c  [15] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
  logic [3:0] dn_sat_c  [12] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
                                 4'd0, 4'd0, 4'd0};

  initial begin
    if_w.en = 1'b0; if_w.upordown = 1'b0; if_w.load = 1'b0; if_w.load_value = '0;
    if_s.en = 1'b0; if_s.upordown = 1'b0; if_s.load = 1'b0; if_s.load_value = '0;

    // wrap-mode instance
    apply(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 1, "reset_a");
    apply(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 1, "reset_b");
    for (int i = 0; i < 12; i++)
      apply(0, 0, 1, 1, 0, 4'd0, up_wrap_c[i], (i == 9), (i == 8), $sformatf("up_wrap_%0d", i));
    apply(0, 0, 1, 0, 1, 4'd1, 4'd1, 0, 0, "load_1");
    apply(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 1, "down_to_0");
    apply(0, 0, 1, 0, 0, 4'd0, 4'd9, 1, 0, "down_wrap_9");
    apply(0, 0, 1, 0, 0, 4'd0, 4'd8, 0, 0, "down_8");
    apply(0, 0, 1, 1, 1, 4'd5, 4'd5, 0, 0, "load_5_over_en");
    apply(0, 0, 1, 1, 0, 4'd0, 4'd6, 0, 0, "step_after_load");
    apply(0, 0, 1, 1, 1, 4'd13, 4'd9, 0, 1, "load_13_clamp");
    apply(0, 0, 0, 1, 0, 4'd0, 4'd9, 0, 1, "hold_tc_up");
    apply(0, 0, 0, 0, 0, 4'd0, 4'd9, 0, 0, "hold_tc_down");
    apply(0, 0, 1, 1, 1, 4'd7, 4'd7, 0, 0, "load_7");
    apply(0, 1, 1, 1, 0, 4'd0, 4'd0, 0, 0, "reset_mid_count");
    apply(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, "resume_1");
    apply(0, 0, 0, 1, 1, 4'd9, 4'd9, 0, 1, "load_9");
    apply(0, 1, 1, 1, 1, 4'd5, 4'd0, 0, 0, "reset_beats_load");
    apply(0, 0, 1, 0, 0, 4'd0, 4'd9, 1, 0, "toggle_wrap_down");
    apply(0, 0, 1, 1, 0, 4'd0, 4'd0, 1, 0, "toggle_wrap_up");
    apply(0, 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, "after_toggle");

    // saturate-mode instance
    apply(1, 1, 1, 0, 0, 4'd0, 4'd0, 0, 1, "sat_reset");
    for (int i = 0; i < 15; i++)
      apply(1, 0, 1, 1, 0, 4'd0, up_sat_c[i], 0, (i >= 8), $sformatf("sat_up_%0d", i));
    for (int i = 0; i < 12; i++)
      apply(1, 0, 1, 0, 0, 4'd0, dn_sat_c[i], 0, (i >= 8), $sformatf("sat_down_%0d", i));
    apply(1, 0, 1, 1, 1, 4'd13, 4'd9, 0, 1, "sat_load_clamp");
    apply(1, 0, 1, 1, 0, 4'd0, 4'd9, 0, 1, "sat_hold_max");

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
